// File: rtl/alu_tile_input_arbiter.sv
// Five-port input arbiter feeding one ALU tile: a one-entry holding register per port,
// round-robin (optionally host-priority) selection into a single registered output stage.
module alu_tile_input_arbiter #(
  parameter bit HOST_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   in_valid,
  output logic [4:0]   in_ready,
  input  logic [319:0] in_a,
  input  logic [319:0] in_b,
  input  logic [79:0]  in_ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_a,
  output logic [63:0]  out_b,
  output logic [15:0]  out_ctrl,
  output logic [2:0]   out_src,
  output logic         busy,
  output logic [15:0]  issued_cnt
);

  localparam int unsigned NumPorts = 5;
  localparam int unsigned DataW    = 64;
  localparam int unsigned CtrlW    = 16;
  localparam logic [2:0]  HostIdx  = 3'd4;

  logic [NumPorts-1:0] full_q, full_d;
  logic [NumPorts-1:0] accept;
  logic [DataW-1:0]    hold_a_q    [NumPorts];
  logic [DataW-1:0]    hold_b_q    [NumPorts];
  logic [CtrlW-1:0]    hold_ctrl_q [NumPorts];

  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             out_valid_q;
  logic [DataW-1:0] out_a_q, out_b_q;
  logic [CtrlW-1:0] out_ctrl_q;
  logic [2:0]       out_src_q;
  logic [15:0]      issued_cnt_q;

  logic       out_free;
  logic       grant_valid;
  logic       host_win;
  logic [2:0] grant_idx;

  // Port index reached k steps after base, wrapping 4 -> 0.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned k);
    int unsigned s;
    s = int'(base) + k;
    if (s >= NumPorts) s = s - NumPorts;
    return 3'(s);
  endfunction

  assign in_ready = ~full_q;
  assign accept   = in_valid & ~full_q;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    grant_valid = 1'b0;
    host_win    = 1'b0;
    grant_idx   = 3'd0;
    if (out_free) begin
      if (HOST_PRIO && full_q[HostIdx]) begin
        grant_valid = 1'b1;
        host_win    = 1'b1;
        grant_idx   = HostIdx;
      end else begin
        for (int unsigned k = 0; k < NumPorts; k++) begin
          if (!grant_valid && full_q[wrap_idx(rr_ptr_q, k)]) begin
            grant_valid = 1'b1;
            grant_idx   = wrap_idx(rr_ptr_q, k);
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    // Host-priority grants bypass the rotation so other ports keep their turn.
    if (grant_valid && !host_win) rr_ptr_d = wrap_idx(grant_idx, 1);
  end

  always_comb begin
    full_d = full_q | accept;
    if (grant_valid) full_d[grant_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumPorts; i++) begin
        hold_a_q[i]    <= '0;
        hold_b_q[i]    <= '0;
        hold_ctrl_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (accept[i]) begin
          hold_a_q[i]    <= in_a[i*DataW +: DataW];
          hold_b_q[i]    <= in_b[i*DataW +: DataW];
          hold_ctrl_q[i] <= in_ctrl[i*CtrlW +: CtrlW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_ctrl_q   <= '0;
      out_src_q    <= '0;
      issued_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      rr_ptr_q <= rr_ptr_d;
      if (grant_valid) begin
        out_valid_q <= 1'b1;
        out_a_q     <= hold_a_q[grant_idx];
        out_b_q     <= hold_b_q[grant_idx];
        out_ctrl_q  <= hold_ctrl_q[grant_idx];
        out_src_q   <= grant_idx;
      end else if (out_free) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready && (issued_cnt_q != 16'hFFFF)) begin
        issued_cnt_q <= issued_cnt_q + 16'd1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_ctrl   = out_ctrl_q;
  assign out_src    = out_src_q;
  assign issued_cnt = issued_cnt_q;
  assign busy       = (|full_q) | out_valid_q;

endmodule

// File: tb/tb_alu_tile_input_arbiter.sv
// Directed bench: reset, round-robin order, backpressure, host priority, single-packet table,
// counter saturation and mid-traffic reset.
module tb_alu_tile_input_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   in_valid, in_ready;
  logic [319:0] in_a, in_b;
  logic [79:0]  in_ctrl;
  logic         out_valid, out_ready, busy;
  logic [63:0]  out_a, out_b;
  logic [15:0]  out_ctrl, issued_cnt;
  logic [2:0]   out_src;

  logic [4:0]   in_valid2, in_ready2;
  logic [319:0] in_a2, in_b2;
  logic [79:0]  in_ctrl2;
  logic         out_valid2, out_ready2, busy2;
  logic [63:0]  out_a2, out_b2;
  logic [15:0]  out_ctrl2, issued_cnt2;
  logic [2:0]   out_src2;

  int n_cmp = 0;
  int n_err = 0;
  int model_hs = 0;

  alu_tile_input_arbiter #(.HOST_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
    .out_src(out_src), .busy(busy), .issued_cnt(issued_cnt)
  );

  alu_tile_input_arbiter #(.HOST_PRIO(1'b1)) dut_prio (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_ctrl(in_ctrl2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_a(out_a2), .out_b(out_b2), .out_ctrl(out_ctrl2),
    .out_src(out_src2), .busy(busy2), .issued_cnt(issued_cnt2)
  );

  always #5 clk = ~clk;

  // Independent handshake count used as the reference for issued_cnt.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_hs <= 0;
    else if (out_valid && out_ready) model_hs <= model_hs + 1;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish, required finish before 5ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          port;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] ctrl;
    logic [2:0]  exp_src;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_port(input int p, input logic [63:0] a, input logic [63:0] b,
                           input logic [15:0] c);
    in_a[p*64 +: 64]    = a;
    in_b[p*64 +: 64]    = b;
    in_ctrl[p*16 +: 16] = c;
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  initial begin
    logic [2:0] prio_seq[8];
    int k;

    vecs[0] = '{1, 64'd1, 64'd2, 16'h0003, 3'd1, 16'd9};
    vecs[1] = '{0, 64'hDEAD_BEEF_0000_0001, 64'h1, 16'hA5A5, 3'd0, 16'd10};
    vecs[2] = '{4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'hFFFF, 3'd4, 16'd11};
    vecs[3] = '{3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 3'd3, 16'd12};
    vecs[4] = '{2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 16'h1234, 3'd2, 16'd13};
    vecs[5] = '{1, 64'h8000_0000_0000_0000, 64'h7FFF, 16'h8001, 3'd1, 16'd14};
    prio_seq = '{3'd4, 3'd0, 3'd4, 3'd1, 3'd4, 3'd0, 3'd4, 3'd1};

    rst_n = 1'b0;
    in_valid = '0; in_a = '0; in_b = '0; in_ctrl = '0; out_ready = 1'b1;
    in_valid2 = '0; in_a2 = '0; in_b2 = '0; in_ctrl2 = '0; out_ready2 = 1'b1;
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'h1F);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_issued", 64'(issued_cnt), 64'h0);
    rst_n = 1'b1;
    step();

    // All five ports at once: rotation 0..4 from rr_ptr=0.
    for (int i = 0; i < 5; i++) load_port(i, 64'h100 + 64'(i), 64'h200 + 64'(i), 16'h30 + 16'(i));
    in_valid = 5'h1F;
    step();
    in_valid = '0;
    check("all5_no_early_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("all5_valid", 64'(out_valid), 64'h1);
      check("all5_src", 64'(out_src), 64'(i));
      check("all5_a", out_a, 64'h100 + 64'(i));
    end
    step();
    check("all5_idle", 64'(out_valid), 64'h0);
    check("all5_cnt", 64'(issued_cnt), 64'd5);

    // Backpressure with N and S full; N refilled while stalled.
    out_ready = 1'b0;
    load_port(0, 64'hA1, 64'hB1, 16'h0C1);
    load_port(2, 64'hA2, 64'hB2, 16'h0C2);
    in_valid = 5'b00101;
    step();
    load_port(0, 64'hA3, 64'hB3, 16'h0C3);
    step();
    check("bp_first_src", 64'(out_src), 64'h0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(out_valid), 64'h1);
      check("bp_src", 64'(out_src), 64'h0);
      check("bp_a", out_a, 64'hA1);
      check("bp_ready_n", 64'(in_ready[0]), 64'h0);
      check("bp_ready_s", 64'(in_ready[2]), 64'h0);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    step();
    check("bp_release_src", 64'(out_src), 64'h2);
    check("bp_release_a", out_a, 64'hA2);
    step();
    check("bp_refill_src", 64'(out_src), 64'h0);
    check("bp_refill_a", out_a, 64'hA3);
    step();
    check("bp_idle", 64'(out_valid), 64'h0);
    check("bp_cnt", 64'(issued_cnt), 64'd8);

    // Host priority: N, E and HOST kept valid continuously.
    in_valid2 = 5'b10011;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      check("prio_valid", 64'(out_valid2), 64'h1);
      check("prio_src", 64'(out_src2), 64'(prio_seq[i]));
    end
    in_valid2 = '0;

    // Single-packet table.
    foreach (vecs[i]) begin
      load_port(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      in_valid = 5'(1 << vecs[i].port);
      step();
      in_valid = '0;
      check("vec_latency", 64'(out_valid), 64'h0);
      step();
      check("vec_valid", 64'(out_valid), 64'h1);
      check("vec_src", 64'(out_src), 64'(vecs[i].exp_src));
      check("vec_a", out_a, vecs[i].a);
      check("vec_b", out_b, vecs[i].b);
      check("vec_ctrl", 64'(out_ctrl), 64'(vecs[i].ctrl));
      step();
      check("vec_cnt", 64'(issued_cnt), 64'(vecs[i].exp_cnt));
    end

    // Counter saturation: bulk traffic, then single packets across the limit.
    in_valid = 5'h1F;
    for (int c = 0; c < 70000 && model_hs < 65520; c++) step();
    in_valid = '0;
    check("bulk_reached", 64'(model_hs >= 65520), 64'h1);
    repeat (8) step();
    check("bulk_cnt", 64'(issued_cnt), 64'(sat16(model_hs)));
    k = 0;
    while (k < 40 && model_hs < 65538) begin
      load_port(k % 5, 64'(k), 64'(k), 16'(k));
      in_valid = 5'(1 << (k % 5));
      step();
      in_valid = '0;
      step(); step();
      check("sat_cnt", 64'(issued_cnt), 64'(sat16(model_hs)));
      k++;
    end
    check("sat_final", 64'(issued_cnt), 64'hFFFF);

    // Reset with three ports full and the output stalled.
    out_ready = 1'b0;
    load_port(0, 64'h11, 64'h11, 16'h11);
    load_port(1, 64'h22, 64'h22, 16'h22);
    load_port(2, 64'h33, 64'h33, 16'h33);
    in_valid = 5'b00111;
    step();
    in_valid = '0;
    check("pre_rst_ready", 64'(in_ready), 64'h18);
    check("pre_rst_busy", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_ready", 64'(in_ready), 64'h1F);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_cnt", 64'(issued_cnt), 64'h0);
    check("mid_rst_a", out_a, 64'h0);
    check("mid_rst_b", out_b, 64'h0);
    check("mid_rst_ctrl", 64'(out_ctrl), 64'h0);
    check("mid_rst_src", 64'(out_src), 64'h0);
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_valid", 64'(out_valid), 64'h0);
    end
    check("post_rst_busy", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
